// File: rtl/alu_op_control.sv
// alu_op_control
// Registered opcode -> ALU operation decoder for the 16-bit datapath.
// Each valid opcode is decoded combinationally and captured on the next
// rising edge, so the ALU sees the operation select one cycle later.
// When no opcode is valid, the operation select and illegal flag keep
// their last values and out_valid drops.
//
// Build option: ALUOP_ILLEGAL_TRAP_EN
//   defined   : unmapped opcodes (0111, 1110, 1111) give aluop = 111 (trap)
//               and illegal = 1.
//   undefined : unmapped opcodes give aluop = 000 (AND, harmless) and the
//               illegal output is held at 0. The port exists in both builds.

module alu_op_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] opcode,
  output logic [2:0] aluop,
  output logic       out_valid,
  output logic       illegal
);

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_NOR  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_TRAP = 3'b111;

`ifdef ALUOP_ILLEGAL_TRAP_EN
  localparam logic [2:0] ILL_ALUOP = ALU_TRAP;
  localparam logic       ILL_FLAG  = 1'b1;
`else
  localparam logic [2:0] ILL_ALUOP = ALU_AND;
  localparam logic       ILL_FLAG  = 1'b0;
`endif

  logic [2:0] dec_aluop;
  logic       dec_illegal;

  logic [2:0] aluop_q,     aluop_d;
  logic       illegal_q,   illegal_d;
  logic       out_valid_q, out_valid_d;

  // Pure opcode decode; everything not explicitly mapped is illegal.
  always_comb begin
    dec_aluop   = ILL_ALUOP;
    dec_illegal = ILL_FLAG;
    case (opcode)
      4'b0000: begin dec_aluop = ALU_AND; dec_illegal = 1'b0; end
      4'b0001: begin dec_aluop = ALU_OR;  dec_illegal = 1'b0; end
      4'b0010: begin dec_aluop = ALU_NOR; dec_illegal = 1'b0; end
      4'b0011: begin dec_aluop = ALU_ADD; dec_illegal = 1'b0; end
      4'b0100: begin dec_aluop = ALU_SUB; dec_illegal = 1'b0; end
      4'b0101: begin dec_aluop = ALU_SLT; dec_illegal = 1'b0; end
      // compare/subtract variant
      4'b0110: begin dec_aluop = ALU_SUB; dec_illegal = 1'b0; end
      // memory address calculation
      4'b1000, 4'b1001,
      4'b1010, 4'b1011: begin dec_aluop = ALU_ADD; dec_illegal = 1'b0; end
      // branch compare
      4'b1100, 4'b1101: begin dec_aluop = ALU_SUB; dec_illegal = 1'b0; end
      default: begin
        dec_aluop   = ILL_ALUOP;
        dec_illegal = ILL_FLAG;
      end
    endcase
  end

  // Capture a new decode only for valid opcodes; otherwise hold, so an
  // undefined opcode with in_valid low never reaches the outputs.
  always_comb begin
    aluop_d     = aluop_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      aluop_d     = dec_aluop;
      illegal_d   = dec_illegal;
      out_valid_d = 1'b1;
    end
  end

  // Output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluop_q     <= ALU_AND;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      aluop_q     <= aluop_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign aluop     = aluop_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_op_control.sv
// Directed testbench for alu_op_control: reset, opcode map, illegal opcodes,
// hold behaviour and asynchronous mid-stream reset.

module tb_alu_op_control;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] opcode;
  logic [2:0] aluop;
  logic       out_valid;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALUOP_ILLEGAL_TRAP_EN
  localparam logic [2:0] EXP_ILL_OP   = 3'b111;
  localparam logic       EXP_ILL_FLAG = 1'b1;
`else
  localparam logic [2:0] EXP_ILL_OP   = 3'b000;
  localparam logic       EXP_ILL_FLAG = 1'b0;
`endif

  alu_op_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .aluop     (aluop),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] e_op,
                           input logic e_valid, input logic e_ill);
    check({tag, ".aluop"},     {29'd0, aluop},     {29'd0, e_op});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
    check({tag, ".illegal"},   {31'd0, illegal},   {31'd0, e_ill});
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] op);
    @(negedge clk);
    in_valid = v;
    opcode   = op;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [2:0] exp_op;
    logic       exp_ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opcode   = 4'b0011;

    // Reset held with a valid opcode present: outputs must stay at reset values.
    #1;
    check_out("reset_init", 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("reset_clk%0d", i), 3'b000, 1'b0, 1'b0);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Core sweep, extended map and illegal opcodes, back-to-back.
    vecs.push_back('{4'b0011, 3'b011, 1'b0});
    vecs.push_back('{4'b0000, 3'b000, 1'b0});
    vecs.push_back('{4'b0110, 3'b100, 1'b0});
    vecs.push_back('{4'b0101, 3'b101, 1'b0});
    vecs.push_back('{4'b0010, 3'b010, 1'b0});
    vecs.push_back('{4'b0001, 3'b001, 1'b0});
    vecs.push_back('{4'b0100, 3'b100, 1'b0});
    vecs.push_back('{4'b1000, 3'b011, 1'b0});
    vecs.push_back('{4'b1001, 3'b011, 1'b0});
    vecs.push_back('{4'b1010, 3'b011, 1'b0});
    vecs.push_back('{4'b1011, 3'b011, 1'b0});
    vecs.push_back('{4'b1100, 3'b100, 1'b0});
    vecs.push_back('{4'b1101, 3'b100, 1'b0});
    vecs.push_back('{4'b0111, EXP_ILL_OP, EXP_ILL_FLAG});
    vecs.push_back('{4'b0001, 3'b001, 1'b0});
    vecs.push_back('{4'b1110, EXP_ILL_OP, EXP_ILL_FLAG});
    vecs.push_back('{4'b0101, 3'b101, 1'b0});
    vecs.push_back('{4'b1111, EXP_ILL_OP, EXP_ILL_FLAG});
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].op);
      check_out($sformatf("map_op%04b", vecs[i].op), vecs[i].exp_op, 1'b1, vecs[i].exp_ill);
    end

    // Hold: one valid SLT, then three idle cycles with a different opcode.
    step(1'b1, 4'b0101);
    check_out("hold_load", 3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000);
      check_out($sformatf("hold_idle%0d", i), 3'b101, 1'b0, 1'b0);
    end

    // Hold after an illegal opcode keeps the illegal result.
    step(1'b1, 4'b1110);
    check_out("hold_ill_load", EXP_ILL_OP, 1'b1, EXP_ILL_FLAG);
    step(1'b0, 4'b0011);
    check_out("hold_ill_idle", EXP_ILL_OP, 1'b0, EXP_ILL_FLAG);

    // Undefined opcode while not valid must not disturb the outputs.
    step(1'b1, 4'b0010);
    check_out("x_load", 3'b010, 1'b1, 1'b0);
    step(1'b0, 4'bxxxx);
    check_out("x_idle", 3'b010, 1'b0, 1'b0);

    // Mid-stream asynchronous reset, asserted between clock edges.
    step(1'b1, 4'b0100);
    check_out("mid_pre", 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_async", 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_held", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    opcode   = 4'b0001;
    #1;
    check_out("mid_release", 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_first", 3'b001, 1'b1, 1'b0);
    step(1'b0, 4'b0000);
    check_out("mid_idle", 3'b001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
